// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared types and helpers for the frequency meter: BCD digit
//                type, converter state encoding and a compile-time power of
//                ten used to build the overflow limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // 10^n as a 64-bit value; only evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter.
//                IDLE -> LOAD -> SHIFT (CNT_W cycles) -> DONE -> IDLE.
//                sat_i, sampled in LOAD, skips the conversion and returns
//                all nines (LOAD -> DONE).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start_i         - begin a conversion (honoured in IDLE)
//                sat_i           - load all-9s instead of converting
//                bin_i[CNT_W]    - binary value, sampled in LOAD
//                bcd_o[4*DIGITS] - working/result register, valid in DONE
//                done_o          - high for the single DONE cycle
//                busy_o          - high in LOAD, SHIFT and DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  sat_i,
  input  logic [CNT_W-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int                c_SH_W = $clog2(CNT_W + 1);
  localparam logic [4*DIGITS-1:0] c_ALL9 = {DIGITS{4'h9}};

  conv_state_t          state_q, state_d;
  logic [CNT_W-1:0]     bin_q, bin_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [4*DIGITS-1:0]  w_adj;
  logic [c_SH_W-1:0]    sh_q, sh_d;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    w_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (sat_i) begin
          bcd_d   = c_ALL9;
          state_d = DONE;
        end else begin
          bcd_d   = '0;
          bin_d   = bin_i;
          sh_d    = c_SH_W'(CNT_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {w_adj, bin_q} << 1;
        sh_d = sh_q - c_SH_W'(1);
        if (sh_q == c_SH_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (state_q == DONE);
  assign busy_o = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meter
//  Description : Counts rising edges of sig_in_i over a fixed gate window and
//                reports each window's count as packed BCD (digit 0 in
//                bits [3:0]). Counts above 10^DIGITS-1 report all-9s with
//                over_o set.
//  Option      : FREQ_METER_HOLD_EN - adds hold_i; while high, bcd_o/over_o
//                freeze and valid_o is suppressed (measurement continues).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                sig_in_i        - asynchronous input to measure
//                hold_i          - display hold (FREQ_METER_HOLD_EN only)
//                bcd_o           - packed BCD result
//                valid_o         - one-cycle pulse when bcd_o/over_o update
//                over_o          - last reported window overflowed
//                busy_o          - BCD conversion in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int F_CLK   = 50000000,
  parameter int GATE_MS = 1000,
  parameter int CNT_W   = 32,
  parameter int DIGITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_in_i,
`ifdef FREQ_METER_HOLD_EN
  input  logic                hold_i,
`endif
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                valid_o,
  output logic                over_o,
  output logic                busy_o
);

  // GATE_CYCLES must exceed CNT_W+4 so a window never closes mid-conversion.
  localparam int                c_GATE_CYCLES = F_CLK / 1000 * GATE_MS;
  localparam int                c_GATE_W      = (c_GATE_CYCLES > 1) ? $clog2(c_GATE_CYCLES) : 1;
  localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(c_GATE_CYCLES - 1);

  // Largest displayable count; overflow is only possible if it fits CNT_W.
  localparam logic [63:0]       c_MAX64  = pow10(DIGITS) - 64'd1;
  localparam bit                c_OVF_EN = (CNT_W < 64) && (c_MAX64 < (64'd1 << CNT_W));
  localparam logic [CNT_W:0]    c_MAX_W  = (CNT_W + 1)'(c_MAX64);

  logic                 s1_q, s2_q, prev_q;
  logic [c_GATE_W-1:0]  gate_q;
  logic [CNT_W-1:0]     edge_q, edge_d;
  logic [CNT_W-1:0]     snap_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic                 over_q;

  logic                 w_rise, w_term, w_over, w_hold, w_upd;
  logic                 w_done, w_busy;
  logic [4*DIGITS-1:0]  w_conv_bcd;

  assign w_rise = s2_q & ~prev_q;
  assign w_term = (gate_q == c_GATE_LAST);

  // Saturating increment; on the terminal cycle this value (including a
  // coincident rise) becomes the snapshot.
  assign edge_d = (w_rise && (edge_q != '1)) ? edge_q + CNT_W'(1) : edge_q;

  // Snapshot is stable for the whole conversion, so the decision can be
  // evaluated combinationally in both LOAD and DONE.
  assign w_over = c_OVF_EN && ({1'b0, snap_q} > c_MAX_W);

`ifdef FREQ_METER_HOLD_EN
  assign w_hold = hold_i;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      gate_q <= '0;
      edge_q <= '0;
      snap_q <= '0;
      bcd_q  <= '0;
      over_q <= 1'b0;
    end else begin
      s1_q   <= sig_in_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      gate_q <= w_term ? '0 : gate_q + c_GATE_W'(1);
      if (w_term) begin
        snap_q <= edge_d;
        edge_q <= '0;
      end else begin
        edge_q <= edge_d;
      end
      if (w_upd) begin
        bcd_q  <= w_conv_bcd;
        over_q <= w_over;
      end
    end
  end

  bin2bcd_seq #(
    .CNT_W  (CNT_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_term),
    .sat_i   (w_over),
    .bin_i   (snap_q),
    .bcd_o   (w_conv_bcd),
    .done_o  (w_done),
    .busy_o  (w_busy)
  );

  // In the DONE cycle the fresh result is passed straight through so that
  // valid_o and the new value appear together; the held copy covers the rest.
  assign w_upd   = w_done & ~w_hold;
  assign valid_o = w_upd;
  assign bcd_o   = w_upd ? w_conv_bcd : bcd_q;
  assign over_o  = w_upd ? w_over : over_q;
  assign busy_o  = w_busy;

  a_no_term_busy : assert property (@(posedge clk) disable iff (rst) !(w_term && w_busy));

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meter
//  Description : Bench for freq_meter. Two instances (DIGITS=8 and DIGITS=1)
//                share clock, reset and input. A window-level reference
//                model counts input rising edges per 100-cycle gate window and
//                predicts valid/bcd/over/busy for every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int c_F_CLK   = 100000;
  localparam int c_GATE_MS = 1;
  localparam int c_GATE    = 100;
  localparam int c_CNT_W   = 32;

  logic        clk;
  logic        rst;
  logic        sig;
  logic        hold;
  logic [31:0] bcd8;
  logic [3:0]  bcd1;
  logic        valid8, valid1, over8, over1, busy8, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  freq_meter #(.F_CLK(c_F_CLK), .GATE_MS(c_GATE_MS), .CNT_W(c_CNT_W), .DIGITS(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .sig_in_i (sig),
`ifdef FREQ_METER_HOLD_EN
    .hold_i   (hold),
`endif
    .bcd_o    (bcd8),
    .valid_o  (valid8),
    .over_o   (over8),
    .busy_o   (busy8)
  );

  freq_meter #(.F_CLK(c_F_CLK), .GATE_MS(c_GATE_MS), .CNT_W(c_CNT_W), .DIGITS(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .sig_in_i (sig),
`ifdef FREQ_METER_HOLD_EN
    .hold_i   (hold),
`endif
    .bcd_o    (bcd1),
    .valid_o  (valid1),
    .over_o   (over1),
    .busy_o   (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic longint unsigned p10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] to_bcd(input longint unsigned n, input int digits);
    logic [63:0] r = '0;
    longint unsigned v = n;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // cyc = index of the cycle following the most recent edge (0 right after
  // the last reset edge). A rise of the input between the samples taken at
  // edges k-1 and k is detected during cycle k+1 and belongs to window
  // floor((k+1)/100). Window w reports in cycle 100w+99+lat, lat = 34 for a
  // normal conversion or 2 when the count exceeds the display range.
  bit          started = 0;
  int          cyc     = 0;
  bit          h1, h2;
  int unsigned cnt [0:255];
  logic [63:0] disp_bcd  [2];
  bit          disp_over [2];

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      cyc     = 0;
      h1      = 0;
      h2      = 0;
      foreach (cnt[i]) cnt[i] = 0;
      for (int d = 0; d < 2; d++) begin
        disp_bcd[d]  = '0;
        disp_over[d] = 0;
      end
    end else if (started) begin
      cyc++;
      if (h1 && !h2) cnt[cyc / c_GATE]++;
      h2 = h1;
      h1 = sig;
    end
  end

  longint unsigned m_max, m_n;
  int              m_w, m_off, m_lat;
  bit              m_ov, m_ev, m_eb;

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        m_max = p10(d == 0 ? 8 : 1) - 1;
        m_ev  = 0;
        m_eb  = 0;
        if (cyc >= c_GATE) begin
          m_w   = (cyc - c_GATE) / c_GATE;
          m_off = (cyc - c_GATE) % c_GATE;
          m_n   = cnt[m_w];
          m_ov  = (m_n > m_max);
          m_lat = m_ov ? 2 : c_CNT_W + 2;
          m_eb  = (m_off < m_lat);
          if (m_off == m_lat - 1 && !hold) begin
            m_ev         = 1;
            disp_bcd[d]  = to_bcd(m_ov ? m_max : m_n, d == 0 ? 8 : 1);
            disp_over[d] = m_ov;
          end
        end
        if (d == 0) begin
          check_eq("valid_d8", 64'(valid8), 64'(m_ev));
          check_eq("busy_d8",  64'(busy8),  64'(m_eb));
          check_eq("bcd_d8",   64'(bcd8),   disp_bcd[0]);
          check_eq("over_d8",  64'(over8),  64'(disp_over[0]));
        end else begin
          check_eq("valid_d1", 64'(valid1), 64'(m_ev));
          check_eq("busy_d1",  64'(busy1),  64'(m_eb));
          check_eq("bcd_d1",   64'(bcd1),   disp_bcd[1]);
          check_eq("over_d1",  64'(over1),  64'(disp_over[1]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input int half, input int ncyc);
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (i % half == 0) sig = ~sig;
    end
  endtask

  initial begin
    rst  = 1'b1;
    sig  = 1'b0;
    hold = 1'b0;

    // Input toggles while in reset; none of it may be counted.
    repeat (10) begin
      step();
      sig = ~sig;
    end
    rst = 1'b0;

    // Period-10 input: 10 edges per window (DIGITS=1 overflows).
    run_period(5, 350);

    // Quiet input, then one rise landing on a terminal cycle.
    sig = 1'b0;
    repeat (250) step();
    while (cyc % c_GATE != 97) step();
    sig = 1'b1;
    repeat (250) step();
    sig = 1'b0;

    // Maximum rate: toggle every cycle.
    run_period(1, 350);

    // Period-20 input: 5 edges per window.
    run_period(10, 350);

`ifdef FREQ_METER_HOLD_EN
    hold = 1'b1;
    run_period(5, 200);
    run_period(10, 150);
    hold = 1'b0;
    run_period(10, 250);
`endif

    // Random input.
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) sig = ~sig;
    end

    // Reset in the middle of a conversion; no result may appear.
    run_period(5, 120);
    while (cyc % c_GATE != 20) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    run_period(5, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
